// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - FIFO read ports, UART launch port and status bundle for uart_tx_arbiter
//
// Purpose: groups the two FIFO read ports (empty flag, show-ahead data, pop strobe),
//          the uart_tx launch port (tx_start, tx_din, tx_done_tick) and the arbiter
//          control/status signals (en, grant, busy).
// Modports:
//   slave  - the arbiter itself (consumes flags/data, drives strobes and status)
//   master - the surrounding environment (FIFOs, uart_tx, controller)
interface uart_tx_arbiter_if #(
    parameter int DBIT = 8
);
    logic            en;
    logic            empty0;
    logic            empty1;
    logic [DBIT-1:0] dout0;
    logic [DBIT-1:0] dout1;
    logic            rd0;
    logic            rd1;
    logic            tx_start;
    logic [DBIT-1:0] tx_din;
    logic            tx_done_tick;
    logic            grant;
    logic            busy;

    modport slave (
        input  en, empty0, empty1, dout0, dout1, tx_done_tick,
        output rd0, rd1, tx_start, tx_din, grant, busy
    );

    modport master (
        output en, empty0, empty1, dout0, dout1, tx_done_tick,
        input  rd0, rd1, tx_start, tx_din, grant, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, burst-limited arbiter sharing one uart_tx between two TX FIFOs
//
// Purpose: picks FIFO0 or FIFO1 in IDLE, pops one byte (rd pulse) and launches it on the
//          UART (tx_start) in a single LOAD cycle, then waits in WAIT for tx_done_tick.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-high
//   bus    - uart_tx_arbiter_if.slave: en, empty0/1, dout0/1, rd0/1, tx_start, tx_din,
//            tx_done_tick, grant, busy
module uart_tx_arbiter #(
    parameter int DBIT  = 8,
    parameter int BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.slave  bus
);
    localparam int BW = $clog2(BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(BURST);
    localparam logic [BW-1:0] ONE       = BW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            grant_q, grant_d;
    logic [DBIT-1:0] tx_din_q, tx_din_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic            ch;

    // burst_q resets to BURST_MAX with grant_q=1 so the very first contested pick goes to channel 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= 1'b1;
            tx_din_q <= '0;
            burst_q  <= BURST_MAX;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            tx_din_q <= tx_din_d;
            burst_q  <= burst_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        tx_din_d = tx_din_q;
        burst_d  = burst_q;
        ch       = grant_q;
        case (state_q)
            IDLE: begin
                if (bus.en && (!bus.empty0 || !bus.empty1)) begin
                    if (!bus.empty0 && !bus.empty1) begin
                        // Stay with the current owner until its burst is used up.
                        ch = (burst_q < BURST_MAX) ? grant_q : ~grant_q;
                    end else begin
                        // Exactly one is non-empty: empty0=1 means channel 1 is the one.
                        ch = bus.empty0;
                    end
                    grant_d  = ch;
                    tx_din_d = ch ? bus.dout1 : bus.dout0;
                    // A channel taken alone keeps counting, so a saturated count forces a
                    // switch as soon as the other FIFO refills.
                    if (ch == grant_q) begin
                        burst_d = (burst_q >= BURST_MAX) ? BURST_MAX : burst_q + ONE;
                    end else begin
                        burst_d = ONE;
                    end
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.tx_done_tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes depend only on registered state and grant, so they carry no input-to-output paths.
    assign bus.rd0      = (state_q == LOAD) && !grant_q;
    assign bus.rd1      = (state_q == LOAD) &&  grant_q;
    assign bus.tx_start = (state_q == LOAD);
    assign bus.tx_din   = tx_din_q;
    assign bus.grant    = grant_q;
    assign bus.busy     = (state_q != IDLE);
endmodule
